ps2_keycode_decoder: RTL and testbench

- Receives PS/2 (scan code set 2) frames from a keyboard and decodes make/break sequences.
- Translates recognised keys to 8-bit USB-HID usage codes and presents the held key on `keycode`.
- Feeds the `keycode` input of the ball motion controller and any other keycode consumer.
- Codes it produces: 0x04 A, 0x07 D, 0x16 S, 0x1A W, plus arrow keys; 0x00 means no key held.

---
 rtl/ps2_pkg.sv | 44 ++++
 rtl/ps2_rx.sv | 164 ++++++++++++++++
 rtl/ps2_keycode_decoder.sv | 124 ++++++++++++
 tb/tb_ps2_keycode_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and decoder.
//   - rx_state_e : receive FSM state encoding
//   - PS2_*      : scan code set 2 prefix bytes
//   - SC_*       : scan codes of the keys we translate
//   - KEY_*      : USB-HID usage codes presented on keycode
package ps2_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Prefix bytes
  localparam logic [BYTE_W-1:0] PS2_EXT  = 8'hE0;
  localparam logic [BYTE_W-1:0] PS2_BRK  = 8'hF0;
  localparam logic [BYTE_W-1:0] KEY_NONE = 8'h00;

  // Scan code set 2 make codes (arrows carry the E0 prefix)
  localparam logic [BYTE_W-1:0] SC_A     = 8'h1C;
  localparam logic [BYTE_W-1:0] SC_D     = 8'h23;
  localparam logic [BYTE_W-1:0] SC_S     = 8'h1B;
  localparam logic [BYTE_W-1:0] SC_W     = 8'h1D;
  localparam logic [BYTE_W-1:0] SC_SPACE = 8'h29;
  localparam logic [BYTE_W-1:0] SC_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_RIGHT = 8'h74;
  localparam logic [BYTE_W-1:0] SC_DOWN  = 8'h72;
  localparam logic [BYTE_W-1:0] SC_UP    = 8'h75;

  // USB-HID usage codes
  localparam logic [BYTE_W-1:0] KEY_A     = 8'h04;
  localparam logic [BYTE_W-1:0] KEY_D     = 8'h07;
  localparam logic [BYTE_W-1:0] KEY_S     = 8'h16;
  localparam logic [BYTE_W-1:0] KEY_W     = 8'h1A;
  localparam logic [BYTE_W-1:0] KEY_SPACE = 8'h2C;
  localparam logic [BYTE_W-1:0] KEY_RIGHT = 8'h4F;
  localparam logic [BYTE_W-1:0] KEY_LEFT  = 8'h50;
  localparam logic [BYTE_W-1:0] KEY_DOWN  = 8'h51;
  localparam logic [BYTE_W-1:0] KEY_UP    = 8'h52;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, ps2_clk glitch filter, frame FSM
// with odd-parity / stop-bit checking and a mid-frame inactivity timeout.
// Ports:
//   clk, rst_n     : system clock, async active-low reset
//   ps2_clk_i      : raw keyboard clock (asynchronous)
//   ps2_data_i     : raw keyboard data (asynchronous)
//   rx_byte_o      : last correctly received byte
//   byte_valid_o   : one-cycle strobe, rx_byte_o is new
//   frame_err_o    : one-cycle strobe on parity/stop error or timeout
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk_i,
  input  logic              ps2_data_i,
  output logic [BYTE_W-1:0] rx_byte_o,
  output logic              byte_valid_o,
  output logic              frame_err_o
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC);
  localparam int unsigned BCW = 3;

  // 2-FF synchronisers, preset to the idle-high bus level
  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_s;
  logic       data_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Clock filter: level flips only after FILTER_LEN consecutive opposite samples
  logic           filt_q, filt_d;
  logic           filt_dly_q;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      fcnt_q     <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      fcnt_q     <= fcnt_d;
    end
  end

  assign fall = filt_dly_q & ~filt_q;

  // Frame FSM
  rx_state_e         state_q, state_d;
  logic [BCW-1:0]    bitcnt_q, bitcnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
  logic              byte_valid_q, byte_valid_d;
  logic              frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tmo_d        = '0;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == RX_IDLE) begin
      if (fall && !data_s) begin
        state_d  = RX_DATA;
        bitcnt_d = '0;
      end
    end else if (fall) begin
      // A falling edge always wins over a coincident timeout
      unique case (state_q)
        RX_DATA: begin
          shift_d  = {data_s, shift_q[BYTE_W-1:1]};
          bitcnt_d = bitcnt_q + BCW'(1);
          if (bitcnt_q == BCW'(BYTE_W - 1)) begin
            state_d = RX_PARITY;
          end
        end
        RX_PARITY: begin
          par_d   = data_s;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (data_s && (^{shift_q, par_q})) begin
            rx_byte_d    = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      frame_err_d = 1'b1;
      state_d     = RX_IDLE;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_byte_o    = rx_byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard decoder: turns make/break sequences (with E0/F0 prefixes)
// into the USB-HID usage of the most recently pressed, still-held key.
// Ports:
//   Clk, Reset_n : system clock, async active-low reset
//   ps2_clk      : raw keyboard clock
//   ps2_data     : raw keyboard data
//   keycode      : held key usage code, 0x00 when none
//   key_event    : one-cycle pulse when keycode changes
//   frame_err    : one-cycle pulse on a bad or timed-out frame
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [BYTE_W-1:0] keycode,
  output logic              key_event,
  output logic              frame_err
);

  logic [BYTE_W-1:0] rx_byte;
  logic              byte_valid;
  logic              rx_err;

  ps2_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .rx_byte_o    (rx_byte),
    .byte_valid_o (byte_valid),
    .frame_err_o  (rx_err)
  );

  // Scan code (with extended flag) to USB usage; 0x00 for unmapped codes
  function automatic logic [BYTE_W-1:0] ps2_to_usb(input logic ext,
                                                   input logic [BYTE_W-1:0] code);
    logic [BYTE_W-1:0] usb;
    usb = KEY_NONE;
    if (!ext) begin
      case (code)
        SC_A:     usb = KEY_A;
        SC_D:     usb = KEY_D;
        SC_S:     usb = KEY_S;
        SC_W:     usb = KEY_W;
        SC_SPACE: usb = KEY_SPACE;
        default:  usb = KEY_NONE;
      endcase
    end else begin
      case (code)
        SC_LEFT:  usb = KEY_LEFT;
        SC_RIGHT: usb = KEY_RIGHT;
        SC_DOWN:  usb = KEY_DOWN;
        SC_UP:    usb = KEY_UP;
        default:  usb = KEY_NONE;
      endcase
    end
    return usb;
  endfunction

  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [BYTE_W-1:0] keycode_q, keycode_d;
  logic              key_event_q, key_event_d;
  logic [BYTE_W-1:0] usb;

  // Prefix tracking and held-key update
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    keycode_d = keycode_q;
    usb       = ps2_to_usb(ext_q, rx_byte);

    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (usb != KEY_NONE) begin
          if (!brk_q) begin
            keycode_d = usb;
          end else if (usb == keycode_q) begin
            // Only releasing the displayed key clears it
            keycode_d = KEY_NONE;
          end
        end
      end
    end

    key_event_d = (keycode_d != keycode_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      keycode_q   <= KEY_NONE;
      key_event_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      keycode_q   <= keycode_d;
      key_event_q <= key_event_d;
    end
  end

  assign keycode   = keycode_q;
  assign key_event = key_event_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Self-checking bench for ps2_keycode_decoder: directed scenarios followed by
// randomized frames, compared against a byte-level behavioural model.
`timescale 1ns/1ps
module tb_ps2_keycode_decoder;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 600;
  localparam int HALF        = 20;   // PS/2 half period in Clk cycles

  logic       Clk;
  logic       Reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_event;
  logic       frame_err;

  ps2_keycode_decoder #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_event (key_event),
    .frame_err (frame_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Pulse monitor
  int cyc      = 0;
  int ev_total = 0;
  int er_total = 0;
  int ev_cyc   = 0;
  int stop_cyc = 0;

  always @(negedge Clk) begin
    cyc <= cyc + 1;
    if (key_event) begin
      ev_total <= ev_total + 1;
      ev_cyc   <= cyc;
    end
    if (frame_err) er_total <= er_total + 1;
  end

  // Behavioural model: byte-level protocol state and a lookup table
  logic [7:0] usb_map [int];
  bit         m_ext, m_brk;
  int         m_key;

  function automatic int lookup(input bit ext, input logic [7:0] b);
    int k;
    k = (ext ? 256 : 0) + int'(b);
    if (usb_map.exists(k)) return int'(usb_map[k]);
    return 0;
  endfunction

  // Returns expected number of keycode changes (0/1)
  function automatic int model_byte(input logic [7:0] b, input bit ok);
    int old;
    int u;
    old = m_key;
    if (!ok) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      u = lookup(m_ext, b);
      if (u != 0) begin
        if (!m_brk) m_key = u;
        else if (u == m_key) m_key = 0;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    return (m_key != old) ? 1 : 0;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Drive nbits of a frame (start, 8 data LSB first, parity, stop)
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits[0]    = 1'b0;
    bits[8:1]  = b;
    bits[9]    = (~^b) ^ bad_par;
    bits[10]   = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int ev0, er0, exp_ev, lat;
    ev0 = ev_total;
    er0 = er_total;
    send_frame(b, bad_par, bad_stop, 11);
    wait_cycles(2 * HALF);
    exp_ev = model_byte(b, !(bad_par || bad_stop));
    check_eq($sformatf("keycode[%02h]", b), int'(keycode), m_key);
    check_eq($sformatf("key_event_cnt[%02h]", b), ev_total - ev0, exp_ev);
    check_eq($sformatf("frame_err_cnt[%02h]", b), er_total - er0,
             (bad_par || bad_stop) ? 1 : 0);
    if (exp_ev == 1) begin
      lat = ev_cyc - stop_cyc;
      check_eq($sformatf("latency_window[%02h] lat=%0d", b, lat),
               (lat >= 10 && lat <= 14) ? 1 : 0, 1);
    end
  endtask

  logic [7:0] pool [11] = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29,
                            8'h6B, 8'h74, 8'h72, 8'h75, 8'hE0, 8'hF0};

  initial begin
    int er0;
    int dummy;
    int r;
    logic [7:0] b;
    bit bp, bs;

    usb_map[8'h1C] = 8'h04;  usb_map[8'h23] = 8'h07;
    usb_map[8'h1B] = 8'h16;  usb_map[8'h1D] = 8'h1A;
    usb_map[8'h29] = 8'h2C;
    usb_map[256 + 8'h6B] = 8'h50;  usb_map[256 + 8'h74] = 8'h4F;
    usb_map[256 + 8'h72] = 8'h51;  usb_map[256 + 8'h75] = 8'h52;
    m_ext = 1'b0;  m_brk = 1'b0;  m_key = 0;

    Reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);
    check_eq("reset_keycode", int'(keycode), 0);
    check_eq("reset_key_event", int'(key_event), 0);
    check_eq("reset_frame_err", int'(frame_err), 0);
    Reset_n = 1'b1;
    wait_cycles(20);

    // Press and release A
    do_frame(8'h1C, 0, 0);
    do_frame(8'hF0, 0, 0);
    do_frame(8'h1C, 0, 0);
    // W, S, release W (not current), release S
    do_frame(8'h1D, 0, 0);
    do_frame(8'h1B, 0, 0);
    do_frame(8'hF0, 0, 0);
    do_frame(8'h1D, 0, 0);
    do_frame(8'hF0, 0, 0);
    do_frame(8'h1B, 0, 0);
    // Extended up arrow make / break
    do_frame(8'hE0, 0, 0);
    do_frame(8'h75, 0, 0);
    do_frame(8'hE0, 0, 0);
    do_frame(8'hF0, 0, 0);
    do_frame(8'h75, 0, 0);
    // Repeat make gives no event; plain 0x75 is unmapped
    do_frame(8'h1C, 0, 0);
    do_frame(8'h1C, 0, 0);
    do_frame(8'h75, 0, 0);
    // Parity error, then valid D
    do_frame(8'h23, 1, 0);
    do_frame(8'h23, 0, 0);
    // Bad stop bit
    do_frame(8'h1B, 0, 1);

    // Timeout mid-frame also drops a pending E0 prefix
    do_frame(8'hE0, 0, 0);
    er0 = er_total;
    send_frame(8'h1B, 0, 0, 6);
    wait_cycles(TIMEOUT_CYC + 60);
    dummy = model_byte(8'h00, 0);
    check_eq("timeout_err_cnt", er_total - er0, 1);
    check_eq("timeout_keycode", int'(keycode), m_key);
    do_frame(8'h75, 0, 0);
    do_frame(8'h1B, 0, 0);

    // Short glitch on ps2_clk with data low must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cycles(3);
    ps2_clk  = 1'b1;
    wait_cycles(30);
    ps2_data = 1'b1;
    wait_cycles(10);
    do_frame(8'h1D, 0, 0);

    // Reset mid-frame
    er0 = er_total;
    send_frame(8'h1C, 0, 0, 5);
    Reset_n = 1'b0;
    #1;
    check_eq("midreset_keycode", int'(keycode), 0);
    check_eq("midreset_frame_err", int'(frame_err), 0);
    m_key = 0;  m_ext = 1'b0;  m_brk = 1'b0;
    wait_cycles(5);
    Reset_n = 1'b1;
    wait_cycles(30);
    check_eq("midreset_err_cnt", er_total - er0, 0);
    do_frame(8'h29, 0, 0);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 15);
      if (r < 11) b = pool[r];
      else if (r == 11) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 4)];
      r  = $urandom_range(0, 9);
      bp = (r == 0);
      bs = (r == 1);
      do_frame(b, bp, bs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
